// File: rtl/sha_compress_stage_if.sv
// Handshake and data bundle between a SHA-256 schedule stage (master side)
// and a compression stage (slave side). Words are 32 bits, a..h packed with
// a in the low word.
`timescale 1ns/1ps

interface sha_compress_stage_if #(
    parameter int W_BLKCNT = 16
);
    logic                      en;
    logic [W_BLKCNT*32-1:0]    W;
    logic [255:0]              state_in;
    logic [255:0]              h_in;
    logic [255:0]              state_out;
    logic                      en_next;
    logic                      busy;

    modport master (
        output en, W, state_in, h_in,
        input  state_out, en_next, busy
    );

    modport slave (
        input  en, W, state_in, h_in,
        output state_out, en_next, busy
    );
endinterface

// File: rtl/sha_compress_stage.sv
// SHA-256 compression stage: runs DELAY rounds (K[ROUND_BASE..], W[W_OFFSET..])
// on the a..h working state, one round per clock, then strobes en_next with the
// registered result. With FEED_FWD the chaining value h_in is added word-wise.
// Round 0 is computed in the accept cycle straight from the bus inputs, so the
// result appears exactly DELAY cycles after en is sampled.
`timescale 1ns/1ps

module sha_compress_stage #(
    parameter int W_BLKCNT   = 16,
    parameter int DELAY      = 16,   // 1..64
    parameter int ROUND_BASE = 0,    // ROUND_BASE + DELAY <= 64
    parameter int W_OFFSET   = 0,    // W_OFFSET + DELAY <= W_BLKCNT
    parameter int FEED_FWD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    sha_compress_stage_if.slave  bus
);

    localparam int                 CNT_W    = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DELAY - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} fsm_e;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One SHA-256 round on a packed {h,g,f,e,d,c,b,a} state.
    function automatic logic [255:0] sha_round(input logic [255:0] s,
                                               input logic [31:0]  k,
                                               input logic [31:0]  wt);
        logic [31:0] a, b, c, d, e, f, g, h;
        logic [31:0] t1, t2;
        {h, g, f, e, d, c, b, a} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + wt;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {g, f, e, d + t1, c, b, a, t1 + t2};
    endfunction

    function automatic logic [255:0] add_words(input logic [255:0] x,
                                               input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
        end
        return r;
    endfunction

    fsm_e               r_fsm;
    fsm_e               w_fsm_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [255:0]       r_state;
    logic [255:0]       r_state_out;
    logic               r_en_next;

    logic               w_start;
    logic               w_adv;
    logic               w_last;
    logic               w_busy;
    logic [5:0]         w_k_idx;
    logic [31:0]        w_wt;
    logic [31:0]        w_w_run;
    logic [255:0]       w_src;
    logic [255:0]       w_round;
    logic [255:0]       w_result;

    // FSM state register.
    // NOTE: sequential state always uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // FSM next-state: a single-round stage never leaves IDLE.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_fsm_nxt = r_fsm;
        unique case (r_fsm)
            ST_IDLE: if (bus.en && (DELAY > 1)) w_fsm_nxt = ST_RUN;
            ST_RUN:  if (r_cnt == CNT_LAST)     w_fsm_nxt = ST_IDLE;
            default: w_fsm_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: accept in IDLE, advance in RUN, flag the final round.
    always_comb begin
        w_start = 1'b0;
        w_adv   = 1'b0;
        w_last  = 1'b0;
        w_busy  = 1'b0;
        unique case (r_fsm)
            ST_IDLE: begin
                w_start = bus.en;
                w_last  = bus.en && (DELAY == 1);
            end
            ST_RUN: begin
                w_adv  = 1'b1;
                w_busy = 1'b1;
                w_last = (r_cnt == CNT_LAST);
            end
            default: ;
        endcase
    end

    // Latched W window; round 0 takes its word straight from the bus.
    if (DELAY > 1) begin : g_win
        logic [31:0] r_w [DELAY];

        // Capture the DELAY window words this stage consumes on accept.
        // NOTE: this word array is reset because a reset must leave every latched register at 0.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DELAY; i++) r_w[i] <= '0;
            end else if (w_start) begin
                for (int i = 0; i < DELAY; i++) r_w[i] <= bus.W[(W_OFFSET + i)*32 +: 32];
            end
        end

        assign w_w_run = r_w[r_cnt];
    end else begin : g_nowin
        assign w_w_run = '0;
    end

    // Round datapath: IDLE works on the incoming state, RUN on the latched one.
    always_comb begin
        w_k_idx = 6'(ROUND_BASE) + 6'(r_cnt);
        if (r_fsm == ST_IDLE) begin
            w_src = bus.state_in;
            w_wt  = bus.W[W_OFFSET*32 +: 32];
        end else begin
            w_src = r_state;
            w_wt  = w_w_run;
        end
        w_round = sha_round(w_src, K_TAB[w_k_idx], w_wt);
    end

    // Optional feed-forward of the chaining value.
    if (FEED_FWD != 0) begin : g_ff
        logic [255:0] r_h_in;
        logic [255:0] w_h_sel;

        // Hold h_in from the accept edge until the final round.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_h_in <= '0;
            end else if (w_start) begin
                r_h_in <= bus.h_in;
            end
        end

        assign w_h_sel  = (r_fsm == ST_IDLE) ? bus.h_in : r_h_in;
        assign w_result = add_words(w_round, w_h_sel);
    end else begin : g_noff
        assign w_result = w_round;
    end

    // Working state, round counter and registered result/strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_state     <= '0;
            r_state_out <= '0;
            r_en_next   <= 1'b0;
        end else begin
            r_en_next <= w_last;
            if (w_start || w_adv) begin
                r_state <= w_round;
            end
            if (w_start) begin
                r_cnt <= (DELAY > 1) ? CNT_W'(1) : '0;
            end else if (w_adv) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_last) begin
                r_state_out <= w_result;
            end
        end
    end

    assign bus.state_out = r_state_out;
    assign bus.en_next   = r_en_next;
    assign bus.busy      = w_busy;

endmodule
